// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the register-file command sequencer.
package regfile_seq_pkg;

    localparam int SEQ_DATA_W = 16;
    localparam int SEQ_ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MOV = 3'd6,
        OP_LDI = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: result, carry/borrow and zero for one op.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W
) (
    input  seq_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    // One extra bit so the top bit is the carry (ADD) or the borrow (SUB).
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    // Select the result for the opcode; NOP yields zero and is ignored upstream.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_ext[DATA_W-1:0];
                carry  = sum_ext[DATA_W];
            end
            OP_SUB: begin
                result = diff_ext[DATA_W-1:0];
                carry  = diff_ext[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            OP_LDI:  result = imm;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-phase command sequencer (IDLE/READ/EXEC/WRITE) driving a 64x16 register file.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int ADDR_W = SEQ_ADDR_W
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdDst,
    input  logic [ADDR_W-1:0] CmdSrc,
    input  logic [DATA_W-1:0] CmdImm,
    output logic [ADDR_W-1:0] RfAddressA,
    output logic [ADDR_W-1:0] RfAddressB,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              RfWriteEnable,
    input  logic [DATA_W-1:0] RfReadDataA,
    input  logic [DATA_W-1:0] RfReadDataB,
    output logic              Done,
    output logic              FlagZ,
    output logic              FlagC
);

    seq_state_t        state_reg, state_next;
    seq_op_t           op_reg;
    logic [ADDR_W-1:0] dst_reg, src_reg;
    logic [DATA_W-1:0] imm_reg, opa_reg, opb_reg, result_reg;
    logic              carry_reg, zero_reg;
    logic              flag_z_reg, flag_c_reg;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_zero;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_reg),
        .a      (opa_reg),
        .b      (opb_reg),
        .imm    (imm_reg),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // State register; reset abandons any command in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next state and state-decoded outputs; addresses/data come straight from registers.
    always_comb begin
        state_next    = state_reg;
        CmdReady      = 1'b0;
        RfWriteEnable = 1'b0;
        Done          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) state_next = ST_READ;
            end
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WRITE;
            ST_WRITE: begin
                Done          = 1'b1;
                RfWriteEnable = (op_reg != OP_NOP);
                state_next    = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    assign RfAddressA  = dst_reg;
    assign RfAddressB  = src_reg;
    assign RfWriteData = result_reg;
    assign FlagZ       = flag_z_reg;
    assign FlagC       = flag_c_reg;

    // Command latch, operand capture, result register and flag update, one per phase.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            op_reg     <= OP_NOP;
            dst_reg    <= '0;
            src_reg    <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (CmdValid) begin
                        op_reg  <= seq_op_t'(CmdOp);
                        dst_reg <= CmdDst;
                        src_reg <= CmdSrc;
                        imm_reg <= CmdImm;
                    end
                end
                ST_READ: begin
                    opa_reg <= RfReadDataA;
                    opb_reg <= RfReadDataB;
                end
                ST_EXEC: begin
                    result_reg <= alu_result;
                    carry_reg  <= alu_carry;
                    zero_reg   <= alu_zero;
                end
                ST_WRITE: begin
                    if (op_reg != OP_NOP) begin
                        flag_z_reg <= zero_reg;
                        flag_c_reg <= carry_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
